// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad BCD entry block: key codes, scanner
// states and the (row, col) to key code map.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StConvert,
    StRelease
  } state_e;

  // Keypad layout:
  //   row0: 1 2 3 A
  //   row1: 4 5 6 B
  //   row2: 7 8 9 C
  //   row3: * 0 # D
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd4_to_bin.sv
// Sequential 4-digit packed BCD to binary converter. One multiply-by-ten-and-add
// step per clock, most significant digit first; done pulses for one clock when
// value holds the result, four clocks after start is sampled.
module bcd4_to_bin (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bcd_in,
  output logic        done,
  output logic [13:0] value
);

  logic [15:0] digits_q;
  logic [13:0] acc_q;
  logic [1:0]  step_q;
  logic        busy_q;

  // Load on start, then shift one digit per clock into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= 16'h0000;
      acc_q    <= 14'd0;
      step_q   <= 2'd0;
      busy_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        digits_q <= bcd_in;
        acc_q    <= 14'd0;
        step_q   <= 2'd0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        // acc * 10 + digit; 9999 fits in 14 bits so no overflow handling
        acc_q    <= (acc_q << 3) + (acc_q << 1) + {10'd0, digits_q[15:12]};
        digits_q <= {digits_q[11:0], 4'h0};
        step_q   <= step_q + 2'd1;
        if (step_q == 2'd3) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign value = acc_q;

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce, feeding a 4-digit packed BCD entry
// register. '#' commits the entry through a sequential BCD to binary converter.
// Optional feature: define KEYPAD_BACKSPACE_EN to make key 'A' a backspace.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  n_row,
  output logic [3:0]  n_col,
  output logic [15:0] bcd,
  output logic [2:0]  digit_count,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [13:0] value,
  output logic        value_valid
);

  localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                                    SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       row_s1, row_s2;
  state_e           state;
  logic [1:0]       col;
  logic [1:0]       row_lat;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  low_row;
  logic [1:0]  next_col;
  logic        any_low;
  logic        latched_low;
  logic [3:0]  cur_key;
  logic        fire;
  logic        conv_start;
  logic        conv_done;
  logic [13:0] conv_value;

  // Two-flop synchroniser for the asynchronous row inputs; idle is all high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= n_row;
      row_s2 <= row_s1;
    end
  end

  // Lowest-index low row wins when several keys share the active column.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2[i]) low_row = 2'(i);
    end
  end

  assign any_low     = ~&row_s2;
  assign next_col    = col + 2'd1;
  assign latched_low = ~row_s2[row_lat];
  assign cur_key     = key_map(row_lat, col);
  assign fire        = (state == StDebounce) && latched_low && (cnt == DEB_LAST);
  assign conv_start  = fire && (cur_key == KEY_HASH);

  bcd4_to_bin u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .bcd_in (bcd),
    .done   (conv_done),
    .value  (conv_value)
  );

  // Scanner FSM with registered outputs and the key actions on the entry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StScan;
      col         <= 2'd0;
      n_col       <= 4'b1110;
      row_lat     <= 2'd0;
      cnt         <= '0;
      bcd         <= 16'h0000;
      digit_count <= 3'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      value       <= 14'd0;
      value_valid <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      value_valid <= 1'b0;
      case (state)
        StScan: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (any_low) begin
              // Column drive holds while the press is qualified.
              row_lat <= low_row;
              state   <= StDebounce;
            end else begin
              col   <= next_col;
              n_col <= ~(4'b0001 << next_col);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StDebounce: begin
          if (!latched_low) begin
            // Bounce: resume scanning this column with a fresh slot.
            state <= StScan;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt       <= '0;
            key_valid <= 1'b1;
            key_code  <= cur_key;
            state     <= (cur_key == KEY_HASH) ? StConvert : StRelease;
            if (cur_key <= 4'd9) begin
              if (digit_count == 3'd0) begin
                bcd         <= {12'h000, cur_key};
                digit_count <= 3'd1;
              end else begin
                bcd <= {bcd[11:0], cur_key};
                if (digit_count != 3'd4) digit_count <= digit_count + 3'd1;
              end
            end else if (cur_key == KEY_STAR) begin
              bcd         <= 16'h0000;
              digit_count <= 3'd0;
            end
`ifdef KEYPAD_BACKSPACE_EN
            else if (cur_key == KEY_A) begin
              bcd <= {4'h0, bcd[15:4]};
              if (digit_count != 3'd0) digit_count <= digit_count - 3'd1;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StConvert: begin
          if (conv_done) begin
            // bcd stays as-is so the display keeps showing the committed entry.
            value       <= conv_value;
            value_valid <= 1'b1;
            digit_count <= 3'd0;
            cnt         <= '0;
            state       <= StRelease;
          end
        end

        StRelease: begin
          if (any_low) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            col   <= 2'd0;
            n_col <= 4'b1110;
            state <= StScan;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= StScan;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Self-checking bench for keypad_bcd_entry: a keypad model drives n_row from
// n_col and a set of pressed keys; the expected entry is tracked as a decimal
// number and digit count.
module tb_keypad_bcd_entry;

  localparam int SC = 4;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  n_row;
  logic [3:0]  n_col;
  logic [15:0] bcd;
  logic [2:0]  digit_count;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] value;
  logic        value_valid;

  keypad_bcd_entry #(
    .SCAN_CYCLES     (SC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .n_row       (n_row),
    .n_col       (n_col),
    .bcd         (bcd),
    .digit_count (digit_count),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .value       (value),
    .value_valid (value_valid)
  );

  always #5 clk = ~clk;

  // pressed[r][c]: key at row r, column c is held down
  logic [3:0] pressed [4];

  always_comb begin
    n_row = 4'hF;
    for (int r = 0; r < 4; r++) n_row[r] = ~|(pressed[r] & ~n_col);
  end

  // Key code -> keypad position
  int pos_r [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
  int pos_c [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc = 0, kv_cnt = 0, vv_cnt = 0, kv_cyc = 0, vv_cyc = 0;

  // Reference model: entry as a decimal number plus digit count
  int m_val = 0, m_cnt = 0, m_commit = 0;

  always @(negedge clk) begin
    cyc++;
    if (key_valid === 1'b1) begin kv_cnt++; kv_cyc = cyc; end
    if (value_valid === 1'b1) begin vv_cnt++; vv_cyc = cyc; end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_cnt == 0) begin
        m_val = k;
        m_cnt = 1;
      end else begin
        m_val = (m_val * 10 + k) % 10000;
        if (m_cnt < 4) m_cnt++;
      end
    end else if (k == 14) begin
      m_val = 0;
      m_cnt = 0;
    end else if (k == 15) begin
      m_commit = m_val;
      m_cnt    = 0;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (k == 10) begin
      m_val = m_val / 10;
      if (m_cnt > 0) m_cnt--;
    end
`endif
  endtask

  // Press key k, hold it `hold` clocks past the key_valid pulse, then release.
  task automatic press(input int k, input int hold);
    int kv0 = kv_cnt;
    int vv0 = vv_cnt;
    int t = 0;
    pressed[pos_r[k]][pos_c[k]] = 1'b1;
    while (kv_cnt == kv0 && t < 300) begin tick(); t++; end
    tests_run++;
    if (kv_cnt == kv0) begin
      tests_failed++;
      $display("FAIL key_valid_timeout key=%0d: got no pulse, required one", k);
    end else if (key_code !== 4'(k)) begin
      tests_failed++;
      $display("FAIL key_code: got %0d, required %0d", key_code, k);
    end
    model_key(k);
    repeat (hold) tick();
    if (k == 15) begin
      tests_run++;
      if (vv_cnt != vv0 + 1 || value !== 14'(m_commit)) begin
        tests_failed++;
        $display("FAIL commit_value: got %0d (pulses %0d), required %0d (1 pulse)",
                 value, vv_cnt - vv0, m_commit);
      end
      tests_run++;
      if (vv_cyc - kv_cyc != 5) begin
        tests_failed++;
        $display("FAIL commit_latency: got %0d, required 5", vv_cyc - kv_cyc);
      end
    end
    pressed[pos_r[k]][pos_c[k]] = 1'b0;
    repeat (30) tick();
    tests_run++;
    if (kv_cnt != kv0 + 1) begin
      tests_failed++;
      $display("FAIL single_key_valid key=%0d: got %0d pulses, required 1", k, kv_cnt - kv0);
    end
    tests_run++;
    if (bcd !== to_bcd(m_val) || digit_count !== 3'(m_cnt)) begin
      tests_failed++;
      $display("FAIL entry key=%0d: got bcd=%h count=%0d, required bcd=%h count=%0d",
               k, bcd, digit_count, to_bcd(m_val), m_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (n_col !== 4'b1110 || bcd !== 16'h0 || digit_count !== 3'd0 || key_valid !== 1'b0 ||
        key_code !== 4'd0 || value !== 14'd0 || value_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got n_col=%b bcd=%h cnt=%0d kv=%b kc=%0d val=%0d vv=%b",
               n_col, bcd, digit_count, key_valid, key_code, value, value_valid);
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_commit_1234();
    press(1, 20);
    press(2, 20);
    press(3, 20);
    press(4, 20);
    press(15, 20);
  endtask

  task automatic test_glitch();
    int kv0 = kv_cnt;
    for (int g = 0; g < 4; g++) begin
      pressed[0][0] = 1'b1;
      repeat (3) tick();
      pressed[0][0] = 1'b0;
      repeat (5) tick();
    end
    tests_run++;
    if (kv_cnt != kv0) begin
      tests_failed++;
      $display("FAIL glitch_no_key: got %0d pulses, required 0", kv_cnt - kv0);
    end
    press(1, 20);
  endtask

  task automatic test_star_clear();
    for (int d = 1; d <= 5; d++) press(d, 15);
    press(14, 15);
    press(15, 20);
  endtask

  task automatic test_9999_hold();
    for (int i = 0; i < 4; i++) press(9, 15);
    press(15, 100);
  endtask

  task automatic test_simultaneous();
    int kv0 = kv_cnt;
    int t = 0;
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    while (kv_cnt == kv0 && t < 300) begin tick(); t++; end
    tests_run++;
    if (key_code !== 4'd1) begin
      tests_failed++;
      $display("FAIL simultaneous_code: got %0d, required 1", key_code);
    end
    model_key(1);
    repeat (20) tick();
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
    repeat (30) tick();
    tests_run++;
    if (kv_cnt != kv0 + 1 || bcd !== to_bcd(m_val)) begin
      tests_failed++;
      $display("FAIL simultaneous_single: got %0d pulses bcd=%h, required 1 pulse bcd=%h",
               kv_cnt - kv0, bcd, to_bcd(m_val));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int k;
      int sel = int'($urandom_range(0, 9));
      if (sel < 6)       k = int'($urandom_range(0, 9));
      else if (sel == 6) k = 14;
      else if (sel == 7) k = 15;
      else               k = int'($urandom_range(10, 13));
      press(k, (k == 15) ? int'($urandom_range(10, 40)) : int'($urandom_range(5, 30)));
    end
  endtask

  task automatic test_reset_mid_convert();
    int kv0 = kv_cnt;
    int vv0;
    int t = 0;
    press(7, 10);
    kv0 = kv_cnt;
    pressed[3][2] = 1'b1;
    while (kv_cnt == kv0 && t < 300) begin tick(); t++; end
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (n_col !== 4'b1110 || bcd !== 16'h0 || digit_count !== 3'd0 || key_valid !== 1'b0 ||
        key_code !== 4'd0 || value !== 14'd0 || value_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_convert: got n_col=%b bcd=%h cnt=%0d kv=%b kc=%0d val=%0d vv=%b",
               n_col, bcd, digit_count, key_valid, key_code, value, value_valid);
    end
    vv0 = vv_cnt;
    pressed[3][2] = 1'b0;
    m_val = 0;
    m_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    tests_run++;
    if (vv_cnt != vv0 || value !== 14'd0) begin
      tests_failed++;
      $display("FAIL no_value_after_reset: got %0d pulses value=%0d, required 0 pulses value=0",
               vv_cnt - vv0, value);
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    test_reset();
    test_commit_1234();
    test_glitch();
    test_star_clear();
    test_9999_hold();
    test_simultaneous();
    test_random();
    test_reset_mid_convert();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_bcd_entry.md
Name: keypad_bcd_entry

Overview:
- Input-side counterpart of the 4-digit multiplexed seven-segment display path: scans a 4x4 matrix keypad and debounces key presses.
- Digit keys are shifted into a 4-digit packed BCD entry register, which can feed the display driver directly.
- On commit, the BCD entry is converted sequentially to binary and a one-cycle valid pulse is issued.

Parameters:
- SCAN_CYCLES, 50000, clocks each column is driven low (1 ms at 50 MHz).
- DEBOUNCE_CYCLES, 500000, clocks the row pattern must be stable for both press and release (10 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- n_row  in  4  keypad rows, active-low, externally pulled up
- n_col  out  4  column drive, active-low, exactly one bit low at all times
- bcd  out  16  entry register, packed BCD, [15:12] is the most significant digit
- digit_count  out  3  digits entered, 0..4
- key_valid  out  1  one-cycle pulse per debounced press
- key_code  out  4  last debounced key: 0-9 digits, 10-13 A-D, 14 '*', 15 '#'
- value  out  14  binary value of the last commit
- value_valid  out  1  one-cycle pulse when value updates

Behaviour:
- Reset values: n_col=4'b1110, bcd=0, digit_count=0, key_valid=0, key_code=0, value=0, value_valid=0, column index=0, state SCAN. Reset acts immediately at any point, including mid-debounce and mid-convert.
- n_row passes through a 2-flop synchroniser; every use below means the synchronised value.
- Keymap by (row, col):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- SCAN state:
  - Drive column index c low for SCAN_CYCLES clocks.
  - Sample rows on the last clock of the slot.
  - If no row is low: c advances, wrapping 3 to 0.
  - If any row is low: latch c and the lowest-index low row, then go to DEBOUNCE. Column drive holds.
- DEBOUNCE state:
  - Count clocks while the latched row stays low.
  - If the row goes high before DEBOUNCE_CYCLES, return to SCAN at the same column with a fresh slot count.
  - When the count reaches DEBOUNCE_CYCLES: pulse key_valid, update key_code, apply the key action on the same edge, then go to RELEASE, or to CONVERT for '#'.
- Key actions:
  - Digit with digit_count==0: bcd={12'h000,d}, digit_count=1.
  - Digit otherwise: bcd={bcd[11:0],d}; the most significant digit is dropped; digit_count saturates at 4.
  - '*': bcd=0, digit_count=0.
  - '#': start commit.
  - A-D: no action, but key_valid still pulses.
- CONVERT state (4 clocks):
  - acc starts at 0.
  - For i=3 down to 0: acc = (acc<<3)+(acc<<1)+bcd[4i+3:4i], computed in 14 bits. Overflow is impossible, since the maximum is 9999.
  - The clock after the 4th step: value=acc, value_valid=1 for one clock, digit_count=0, bcd retained for display. Then go to RELEASE.
  - Commit with digit_count==0 still converts the retained bcd.
  - Commit latency: '#' key_valid edge + 5 clocks to value_valid.
- RELEASE state:
  - Hold the column.
  - Wait for all rows high for DEBOUNCE_CYCLES consecutive clocks; any low row restarts the count.
  - Then return to SCAN at column 0.
  - Held keys therefore never auto-repeat.
- Simultaneous keys: only the lowest row in the first column found is reported; other keys are ignored until release.
- Key presses during CONVERT or RELEASE are not registered.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: key 'A' (code 10) performs backspace: bcd={4'h0,bcd[15:4]}, digit_count decrements and saturates at 0; key_valid pulses.
- Undefined: 'A' has no action, identical to B-D.

Decomposition:
- Package keypad_pkg holds:
  - Key code constants KEY_STAR=14, KEY_HASH=15, KEY_A..KEY_D.
  - State encoding SCAN/DEBOUNCE/CONVERT/RELEASE.
  - The (row, col) to key_code map as a function.
- Natural sub-module: bcd4_to_bin, the sequential multiply-add converter, with start/bcd_in inputs and done/value outputs, 4-cycle latency.
- The scanner FSM stays in the top module.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8):
- Press '1','2','3','4','#', each held 20 clocks with 20 clocks release -> bcd=16'h1234, digit_count 4 then 0, value=14'd1234, value_valid high exactly 1 clock, 5 clocks after the '#' key_valid.
- Press row0 in col0 with a 3-clock glitch before holding steady -> no key_valid during the glitch; exactly one key_valid with key_code=1 after 8 stable clocks.
- Enter 1,2,3,4,5 -> bcd=16'h2345, digit_count=4; then '*' -> bcd=0, digit_count=0; then '#' -> value=0, value_valid pulse.
- Enter 9,9,9,9,'#' -> value=14'd9999; hold '#' for 100 clocks -> single value_valid, no repeat.
- Rows 0 and 2 low together in col0 -> key_code=1 (not 7); one key_valid.
- Assert rst mid-CONVERT -> value_valid never pulses, all outputs at reset values, n_col=4'b1110 immediately.
